dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/sys_defs.sv | 26 ++
 rtl/dmem_responder_if.sv | 23 ++
 rtl/dmem_latency_pipe.sv | 28 ++
 rtl/dmem_responder.sv | 60 ++++++
 tb/tb_dmem_responder.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/sys_defs.sv
// rtl/sys_defs.sv - shared bus encodings, tag type and memory defaults
package sys_defs;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_command_t;

  // Tag 0 is reserved to mean "no tag"
  typedef logic [3:0] mem_tag_t;
  localparam mem_tag_t TAG_INVALID = 4'd0;

  localparam int DEFAULT_MEM_LATENCY = 4;

  typedef struct packed {
    logic        valid;
    mem_tag_t    tag;
    logic [63:0] data;
  } pipe_entry_t;

  function automatic mem_tag_t next_tag(input mem_tag_t tag);
    return (tag == 4'd15) ? 4'd1 : tag + 4'd1;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - processor-to-memory request/response bus
interface dmem_responder_if;
  import sys_defs::*;

  bus_command_t proc2mem_command;
  logic [31:0]  proc2mem_addr;
  logic [63:0]  proc2mem_data;
  logic         mem_stall;
  mem_tag_t     mem2proc_response;
  logic [63:0]  mem2proc_data;
  mem_tag_t     mem2proc_tag;

  modport master (
    output proc2mem_command, proc2mem_addr, proc2mem_data, mem_stall,
    input  mem2proc_response, mem2proc_data, mem2proc_tag
  );

  modport slave (
    input  proc2mem_command, proc2mem_addr, proc2mem_data, mem_stall,
    output mem2proc_response, mem2proc_data, mem2proc_tag
  );

endinterface

// File: rtl/dmem_latency_pipe.sv
// rtl/dmem_latency_pipe.sv - fixed-depth valid/tag/data shift pipeline for load returns
module dmem_latency_pipe
  import sys_defs::*;
#(
  parameter int DEPTH = DEFAULT_MEM_LATENCY
) (
  input  logic        clock,
  input  logic        reset,
  input  pipe_entry_t entry_i,
  output mem_tag_t    tag_o,
  output logic [63:0] data_o
);

  pipe_entry_t stage_q [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= entry_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o  = stage_q[DEPTH-1].valid ? stage_q[DEPTH-1].tag  : TAG_INVALID;
  assign data_o = stage_q[DEPTH-1].valid ? stage_q[DEPTH-1].data : 64'd0;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - tagged fixed-latency data memory responder
module dmem_responder
  import sys_defs::*;
#(
  parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY,
  parameter int MEM_WORDS   = 256
) (
  input  logic              clock,
  input  logic              reset,
  dmem_responder_if.slave   bus
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  logic [63:0]      mem_q [MEM_WORDS];
  mem_tag_t         tag_q, tag_d;
  logic             accept;
  logic [IDX_W-1:0] word_idx;
  pipe_entry_t      load_entry;
  logic             unused_addr_bits;

  // Upper address bits alias onto the same word; byte offset is ignored
  assign word_idx         = bus.proc2mem_addr[3 +: IDX_W];
  assign unused_addr_bits = ^{bus.proc2mem_addr[2:0], bus.proc2mem_addr[31:3+IDX_W]};

  assign accept = !reset && !bus.mem_stall && (bus.proc2mem_command != BUS_NONE);
  assign bus.mem2proc_response = accept ? tag_q : TAG_INVALID;

  always_comb begin
    tag_d = tag_q;
    if (accept) tag_d = next_tag(tag_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tag_q <= 4'd1;
      for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
    end else begin
      tag_q <= tag_d;
      if (accept && bus.proc2mem_command == BUS_STORE) mem_q[word_idx] <= bus.proc2mem_data;
    end
  end

  // Load data is captured at acceptance, so later stores cannot disturb it
  always_comb begin
    load_entry       = '0;
    load_entry.valid = accept && (bus.proc2mem_command == BUS_LOAD);
    load_entry.tag   = tag_q;
    load_entry.data  = mem_q[word_idx];
  end

  dmem_latency_pipe #(.DEPTH(MEM_LATENCY)) u_pipe (
    .clock   (clock),
    .reset   (reset),
    .entry_i (load_entry),
    .tag_o   (bus.mem2proc_tag),
    .data_o  (bus.mem2proc_data)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized and directed self-checking bench for dmem_responder
module tb_dmem_responder;
  import sys_defs::*;

  localparam int LAT   = 4;
  localparam int WORDS = 256;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  dmem_responder_if bus();

  dmem_responder #(.MEM_LATENCY(LAT), .MEM_WORDS(WORDS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit known  = 1'b0;

  // Reference: flat word array, accepted-command count, due-time queue of completions
  logic [63:0] mdl_mem [WORDS];
  int          n_acc;
  typedef struct {
    int          due;
    logic [3:0]  tag;
    logic [63:0] data;
  } comp_t;
  comp_t pend[$];

  logic [3:0]  last_resp;
  logic [3:0]  last_otag;
  logic [63:0] last_odata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic rst, input bus_command_t cmd, input logic [31:0] addr,
                      input logic [63:0] data, input logic stall);
    logic [3:0]  exp_tag;
    logic [63:0] exp_data;
    logic [3:0]  exp_resp;
    int          idx;
    @(negedge clock);
    reset                 = rst;
    bus.proc2mem_command  = cmd;
    bus.proc2mem_addr     = addr;
    bus.proc2mem_data     = data;
    bus.mem_stall         = stall;
    #1;
    exp_tag  = 4'd0;
    exp_data = 64'd0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      exp_tag  = pend[0].tag;
      exp_data = pend[0].data;
      pend.delete(0);
    end
    if (known) begin
      chk("completion_tag", bus.mem2proc_tag, exp_tag);
      chk("completion_data", bus.mem2proc_data, exp_data);
    end
    last_otag  = bus.mem2proc_tag;
    last_odata = bus.mem2proc_data;
    idx = int'((addr >> 3) % WORDS);
    if (rst) begin
      exp_resp = 4'd0;
      for (int i = 0; i < WORDS; i++) mdl_mem[i] = 64'd0;
      n_acc = 0;
      pend.delete();
      known = 1'b1;
    end else if (cmd != BUS_NONE && !stall) begin
      exp_resp = 4'((n_acc % 15) + 1);
      n_acc++;
      if (cmd == BUS_LOAD) pend.push_back('{cyc + LAT, exp_resp, mdl_mem[idx]});
      else mdl_mem[idx] = data;
    end else begin
      exp_resp = 4'd0;
    end
    chk("response", bus.mem2proc_response, exp_resp);
    last_resp = bus.mem2proc_response;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, BUS_NONE, 32'd0, 64'd0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, BUS_NONE, 32'd0, 64'd0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    bus.proc2mem_command = BUS_NONE;
    bus.proc2mem_addr    = '0;
    bus.proc2mem_data    = '0;
    bus.mem_stall        = 1'b0;

    // Store then load same word: tag 2 returns stored data at cycle 5
    do_reset();
    chk("post_reset_tag", last_otag, 4'd0);
    step(1'b0, BUS_STORE, 32'h100, 64'hDEADBEEF_00000001, 1'b0);
    chk("st_ld_resp0", last_resp, 4'd1);
    step(1'b0, BUS_LOAD, 32'h100, 64'd0, 1'b0);
    chk("st_ld_resp1", last_resp, 4'd2);
    idle(3);
    step(1'b0, BUS_NONE, 32'd0, 64'd0, 1'b0);
    chk("st_ld_tag_c5", last_otag, 4'd2);
    chk("st_ld_data_c5", last_odata, 64'hDEADBEEF_00000001);
    idle(2);

    // Three back-to-back loads
    do_reset();
    step(1'b0, BUS_LOAD, 32'h08, 64'd0, 1'b0); chk("b2b_resp0", last_resp, 4'd1);
    step(1'b0, BUS_LOAD, 32'h10, 64'd0, 1'b0); chk("b2b_resp1", last_resp, 4'd2);
    step(1'b0, BUS_LOAD, 32'h18, 64'd0, 1'b0); chk("b2b_resp2", last_resp, 4'd3);
    idle(1); chk("b2b_tag_c3", last_otag, 4'd0);
    idle(1); chk("b2b_tag_c4", last_otag, 4'd1);
    idle(1); chk("b2b_tag_c5", last_otag, 4'd2);
    idle(1); chk("b2b_tag_c6", last_otag, 4'd3);
    idle(1); chk("b2b_tag_c7", last_otag, 4'd0);

    // Stall refuses and does not advance the counter
    do_reset();
    step(1'b0, BUS_LOAD, 32'h40, 64'd0, 1'b1); chk("stall_resp", last_resp, 4'd0);
    step(1'b0, BUS_LOAD, 32'h40, 64'd0, 1'b0); chk("unstall_resp", last_resp, 4'd1);
    idle(LAT + 1);

    // Sixteen loads: counter wraps 15 -> 1
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1'b0, BUS_LOAD, 32'(i * 8), 64'd0, 1'b0);
      chk("wrap_resp", last_resp, (i < 15) ? 4'(i + 1) : 4'd1);
    end
    idle(LAT + 1);

    // Load sees acceptance-time data even if a store follows
    do_reset();
    step(1'b0, BUS_LOAD, 32'h20, 64'd0, 1'b0);
    step(1'b0, BUS_STORE, 32'h20, 64'h55, 1'b0);
    idle(2);
    step(1'b0, BUS_NONE, 32'd0, 64'd0, 1'b0);
    chk("ld_st_tag_c4", last_otag, 4'd1);
    chk("ld_st_data_c4", last_odata, 64'd0);
    idle(2);

    // Reset discards an in-flight load
    do_reset();
    step(1'b0, BUS_LOAD, 32'h30, 64'd0, 1'b0);
    idle(1);
    step(1'b1, BUS_LOAD, 32'h30, 64'd0, 1'b0);
    chk("rst_resp", last_resp, 4'd0);
    for (int i = 3; i <= 8; i++) begin
      idle(1);
      chk("rst_flush_tag", last_otag, 4'd0);
    end
    step(1'b0, BUS_LOAD, 32'h30, 64'd0, 1'b0);
    chk("rst_next_resp", last_resp, 4'd1);
    idle(LAT + 1);

    // Randomized traffic with occasional resets and heavy word reuse
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic         r_rst;
      bus_command_t r_cmd;
      logic [31:0]  r_addr;
      logic         r_stall;
      r_rst   = ($urandom_range(0, 199) == 0);
      case ($urandom_range(0, 2))
        0:       r_cmd = BUS_NONE;
        1:       r_cmd = BUS_LOAD;
        default: r_cmd = BUS_STORE;
      endcase
      r_addr  = ($urandom & 32'hFFFF_F807) | (32'($urandom_range(0, 15)) << 3);
      r_stall = ($urandom_range(0, 3) == 0);
      step(r_rst, r_cmd, r_addr, {$urandom, $urandom}, r_stall);
    end
    idle(LAT + 2);
    chk("drain_empty", 64'(pend.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
